// File: rtl/sram_stream_loader.sv
// Streaming SRAM bank loader: takes a valid/ready word stream and writes it into one
// selected bank at consecutive addresses, reporting completion and command errors.
module sram_stream_loader #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 18,
    parameter int DEPTH     = 784,
    parameter int NUM_BANKS = 10,
    parameter int BANK_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      length,
    input  logic [BANK_W-1:0]    bank_sel,
    input  logic                 abort,
    input  logic                 s_valid,
    input  logic [DATA_W-1:0]    s_data,
    output logic                 s_ready,
    output logic [NUM_BANKS-1:0] sram_we,
    output logic [ADDR_W-1:0]    sram_addr,
    output logic [DATA_W-1:0]    sram_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ADDR_W:0]      words_written
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Range check runs two bits wider than the address so base_addr+length cannot wrap.
    localparam logic [ADDR_W+1:0] DEPTH_LIM     = (ADDR_W+2)'(DEPTH);
    localparam logic [BANK_W:0]   NUM_BANKS_LIM = (BANK_W+1)'(NUM_BANKS);
    localparam logic [ADDR_W:0]   ONE_LEFT      = (ADDR_W+1)'(1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_W-1:0]     addr_q;
    logic [ADDR_W:0]       remaining;
    logic [BANK_W-1:0]     bank_q;
    logic [ADDR_W+1:0]     end_addr;
    logic [NUM_BANKS-1:0]  we_onehot;
    logic                  cmd_take;
    logic                  cmd_bad;
    logic                  cmd_empty;
    logic                  accept;

    // Command decode, evaluated only when a start is taken in IDLE.
    always_comb begin
        end_addr  = {2'b00, base_addr} + {1'b0, length};
        cmd_bad   = ({1'b0, bank_sel} >= NUM_BANKS_LIM) || (end_addr > DEPTH_LIM);
        cmd_empty = (length == '0);
        we_onehot = {{(NUM_BANKS-1){1'b0}}, 1'b1} << bank_q;
    end

    assign cmd_take = (state == IDLE) && start;
    assign accept   = s_ready && s_valid;

    // NOTE: state and datapath registers use non-blocking assignments so every flop
    // samples the values from before the clock edge, regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, otherwise a path through
    // the case that skips an assignment would infer a latch.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (cmd_bad || cmd_empty) ? DONE : LOAD;
                end
            end
            LOAD: begin
                busy    = 1'b1;
                s_ready = (remaining != '0) && !abort;
                if (abort) begin
                    state_next = IDLE;
                end else if (s_valid && (remaining == ONE_LEFT)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Write port and bookkeeping; sram_addr/sram_wdata hold between writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q        <= '0;
            remaining     <= '0;
            bank_q        <= '0;
            err           <= 1'b0;
            words_written <= '0;
            sram_we       <= '0;
            sram_addr     <= '0;
            sram_wdata    <= '0;
        end else begin
            sram_we <= '0;
            if (cmd_take) begin
                addr_q        <= base_addr;
                remaining     <= length;
                bank_q        <= bank_sel;
                err           <= cmd_bad;
                words_written <= '0;
            end else if (accept) begin
                sram_we       <= we_onehot;
                sram_addr     <= addr_q;
                sram_wdata    <= s_data;
                addr_q        <= addr_q + 1'b1;
                remaining     <= remaining - 1'b1;
                words_written <= words_written + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_stream_loader.sv
// Self-checking bench for sram_stream_loader: a table of per-cycle vectors plus
// hand-written sequences for the long load, abort and asynchronous reset cases.
module tb_sram_stream_loader;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 18;
    localparam int DEPTH     = 784;
    localparam int NUM_BANKS = 10;
    localparam int BANK_W    = 4;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic [ADDR_W-1:0]    base_addr;
    logic [ADDR_W:0]      length;
    logic [BANK_W-1:0]    bank_sel;
    logic                 abort;
    logic                 s_valid;
    logic [DATA_W-1:0]    s_data;
    logic                 s_ready;
    logic [NUM_BANKS-1:0] sram_we;
    logic [ADDR_W-1:0]    sram_addr;
    logic [DATA_W-1:0]    sram_wdata;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [ADDR_W:0]      words_written;

    int n_checks = 0;
    int n_fail   = 0;

    sram_stream_loader #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .NUM_BANKS(NUM_BANKS),
        .BANK_W   (BANK_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .bank_sel     (bank_sel),
        .abort        (abort),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_written(words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = inputs driven at a negedge and the outputs expected 1 ns later.
    typedef struct {
        int start;
        int base;
        int len;
        int bank;
        int abort;
        int valid;
        int data;
        int e_ready;
        int e_we;
        int e_addr;
        int e_wdata;
        int e_busy;
        int e_done;
        int e_err;
        int e_ww;
    } vec_t;

    vec_t tbl[28];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int r, input int we, input int addr,
                             input int wd, input int bsy, input int dn, input int er,
                             input int ww);
        check({tag, ".s_ready"},       32'(s_ready),       r);
        check({tag, ".sram_we"},       32'(sram_we),       we);
        check({tag, ".sram_addr"},     32'(sram_addr),     addr);
        check({tag, ".sram_wdata"},    32'(sram_wdata),    wd);
        check({tag, ".busy"},          32'(busy),          bsy);
        check({tag, ".done"},          32'(done),          dn);
        check({tag, ".err"},           32'(err),           er);
        check({tag, ".words_written"}, 32'(words_written), ww);
    endtask

    task automatic drive(input int st, input int ba, input int ln, input int bk,
                         input int ab, input int va, input int da);
        start     = 1'(st);
        base_addr = ADDR_W'(ba);
        length    = (ADDR_W+1)'(ln);
        bank_sel  = BANK_W'(bk);
        abort     = 1'(ab);
        s_valid   = 1'(va);
        s_data    = DATA_W'(da);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nom_bad;
        int nom_writes;

        //          st  base len bank ab va data    | rdy we      addr wdata    bsy dn er ww
        tbl[0]  = '{1, 100,   4,  5, 0, 0, 'h0000,   0, 'h000,   0, 'h0000,  0, 0, 0, 0};
        tbl[1]  = '{0,   0,   0,  0, 0, 1, 'h1001,   1, 'h000,   0, 'h0000,  1, 0, 0, 0};
        tbl[2]  = '{0,   0,   0,  0, 0, 0, 'h0000,   1, 'h020, 100, 'h1001,  1, 0, 0, 1};
        tbl[3]  = '{0,   0,   0,  0, 0, 1, 'h1002,   1, 'h000, 100, 'h1001,  1, 0, 0, 1};
        tbl[4]  = '{0,   0,   0,  0, 0, 1, 'h1003,   1, 'h020, 101, 'h1002,  1, 0, 0, 2};
        tbl[5]  = '{0,   0,   0,  0, 0, 0, 'h0000,   1, 'h020, 102, 'h1003,  1, 0, 0, 3};
        tbl[6]  = '{0,   0,   0,  0, 0, 1, 'h1004,   1, 'h000, 102, 'h1003,  1, 0, 0, 3};
        tbl[7]  = '{0,   0,   0,  0, 0, 1, 'h1005,   0, 'h020, 103, 'h1004,  0, 1, 0, 4};
        tbl[8]  = '{0,   0,   0,  0, 0, 0, 'h0000,   0, 'h000, 103, 'h1004,  0, 0, 0, 4};
        // bad bank select
        tbl[9]  = '{1,   0,   5, 10, 0, 0, 'h0000,   0, 'h000, 103, 'h1004,  0, 0, 0, 4};
        tbl[10] = '{0,   0,   0,  0, 0, 0, 'h0000,   0, 'h000, 103, 'h1004,  0, 1, 1, 0};
        tbl[11] = '{0,   0,   0,  0, 0, 0, 'h0000,   0, 'h000, 103, 'h1004,  0, 0, 1, 0};
        // range overflow 700+100 > 784
        tbl[12] = '{1, 700, 100,  2, 0, 0, 'h0000,   0, 'h000, 103, 'h1004,  0, 0, 1, 0};
        tbl[13] = '{0,   0,   0,  0, 0, 0, 'h0000,   0, 'h000, 103, 'h1004,  0, 1, 1, 0};
        tbl[14] = '{0,   0,   0,  0, 0, 0, 'h0000,   0, 'h000, 103, 'h1004,  0, 0, 1, 0};
        // zero length clears err, no write
        tbl[15] = '{1,   5,   0,  1, 0, 0, 'h0000,   0, 'h000, 103, 'h1004,  0, 0, 1, 0};
        tbl[16] = '{0,   0,   0,  0, 0, 0, 'h0000,   0, 'h000, 103, 'h1004,  0, 1, 0, 0};
        tbl[17] = '{0,   0,   0,  0, 0, 0, 'h0000,   0, 'h000, 103, 'h1004,  0, 0, 0, 0};
        // last legal window 780..783 in bank 9, start+abort in IDLE: start wins
        tbl[18] = '{1, 780,   4,  9, 1, 1, 'h2000,   0, 'h000, 103, 'h1004,  0, 0, 0, 0};
        tbl[19] = '{0,   0,   0,  0, 0, 1, 'h2000,   1, 'h000, 103, 'h1004,  1, 0, 0, 0};
        tbl[20] = '{0,   0,   0,  0, 0, 1, 'h2001,   1, 'h200, 780, 'h2000,  1, 0, 0, 1};
        tbl[21] = '{0,   0,   0,  0, 0, 1, 'h2002,   1, 'h200, 781, 'h2001,  1, 0, 0, 2};
        tbl[22] = '{0,   0,   0,  0, 0, 1, 'h2003,   1, 'h200, 782, 'h2002,  1, 0, 0, 3};
        tbl[23] = '{0,   0,   0,  0, 0, 1, 'h2004,   0, 'h200, 783, 'h2003,  0, 1, 0, 4};
        tbl[24] = '{0,   0,   0,  0, 0, 0, 'h0000,   0, 'h000, 783, 'h2003,  0, 0, 0, 4};
        // one past the end: 781+4 = 785
        tbl[25] = '{1, 781,   4,  0, 0, 0, 'h0000,   0, 'h000, 783, 'h2003,  0, 0, 0, 4};
        tbl[26] = '{0,   0,   0,  0, 0, 0, 'h0000,   0, 'h000, 783, 'h2003,  0, 1, 1, 0};
        tbl[27] = '{0,   0,   0,  0, 0, 0, 'h0000,   0, 'h000, 783, 'h2003,  0, 0, 1, 0};

        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;

        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            drive(tbl[i].start, tbl[i].base, tbl[i].len, tbl[i].bank,
                  tbl[i].abort, tbl[i].valid, tbl[i].data);
            #1;
            check_all($sformatf("row%0d", i), tbl[i].e_ready, tbl[i].e_we, tbl[i].e_addr,
                      tbl[i].e_wdata, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_err, tbl[i].e_ww);
        end

        // Nominal full-bank load into bank 3, data equal to address.
        @(negedge clk);
        drive(1, 0, DEPTH, 3, 0, 0, 0);
        nom_bad    = 0;
        nom_writes = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 1, i);
            #1;
            if (s_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b1) nom_bad++;
            if (i == 0) begin
                if (sram_we !== '0 || err !== 1'b0) nom_bad++;
            end else if (sram_we === 10'h008) begin
                nom_writes++;
                if (sram_addr !== ADDR_W'(i-1) || sram_wdata !== DATA_W'(i-1)) nom_bad++;
            end else begin
                nom_bad++;
            end
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        if (sram_we === 10'h008) nom_writes++;
        check("nominal.stream_errors", nom_bad, 0);
        check("nominal.write_count", nom_writes, DEPTH);
        check_all("nominal.last", 0, 'h008, 783, 783, 0, 1, 0, DEPTH);
        @(negedge clk);
        #1;
        check_all("nominal.idle", 0, 0, 783, 783, 0, 0, 0, DEPTH);

        // Abort after 5 acceptances; a start mid-load must be ignored.
        @(negedge clk);
        drive(1, 50, 10, 7, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 2) drive(1, 0, 1, 0, 0, 1, 'h300 + k);
            else        drive(0, 0, 0, 0, 0, 1, 'h300 + k);
            #1;
            if (k == 0) check_all("abort.c0", 1, 0, 783, 783, 1, 0, 0, 0);
            else        check_all($sformatf("abort.c%0d", k), 1, 'h080, 50 + k - 1,
                                  'h300 + k - 1, 1, 0, 0, k);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 1, 'h305);
        #1;
        check_all("abort.cycle", 0, 'h080, 54, 'h304, 1, 0, 0, 5);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 'h306);
        #1;
        check_all("abort.idle", 0, 0, 54, 'h304, 0, 0, 0, 5);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check_all("abort.no_done", 0, 0, 54, 'h304, 0, 0, 0, 5);

        // Asynchronous reset between edges after 3 words, then a fresh load.
        @(negedge clk);
        drive(1, 200, 10, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 1, 'h400 + k);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 'h403);
        #1;
        check_all("rst.before", 1, 'h002, 202, 'h402, 1, 0, 0, 3);
        #2;
        reset = 1'b0;
        #1;
        check_all("rst.async", 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        drive(1, 300, 2, 4, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 'h500);
        #1;
        check_all("rst.reload0", 1, 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 'h501);
        #1;
        check_all("rst.reload1", 1, 'h010, 300, 'h500, 1, 0, 0, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check_all("rst.reload_done", 0, 'h010, 301, 'h501, 0, 1, 0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
